// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane constants.
// LSU_MISALIGN_EN adds the ERR state used for misaligned-access responses.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StMerge,
`ifdef LSU_MISALIGN_EN
        StWr,
        StErr
`else
        StWr
`endif
    } lsu_state_e;

    // Size 2'b11 is treated as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// Little-endian lanes; half accesses use offset bit 1 only.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_shamt;
    logic [4:0]  half_shamt;
    logic [31:0] byte_lane;
    logic [31:0] half_lane;
    logic [4:0]  merge_shamt;
    logic [31:0] merge_mask;

    assign byte_shamt = {offset_i, 3'b000};
    assign half_shamt = {offset_i[1], 4'b0000};
    assign byte_lane  = rd_word_i >> byte_shamt;
    assign half_lane  = rd_word_i >> half_shamt;

    always_comb begin
        rdata_o = rd_word_i;
        if (!is_word(size_i)) begin
            if (size_i == SZ_HALF) begin
                rdata_o = {{16{~unsigned_i & half_lane[15]}}, half_lane[15:0]};
            end else begin
                rdata_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane[7:0]};
            end
        end
    end

    always_comb begin
        merge_shamt = byte_shamt;
        merge_mask  = BYTE_MASK << byte_shamt;
        if (size_i == SZ_HALF) begin
            merge_shamt = half_shamt;
            merge_mask  = HALF_MASK << half_shamt;
        end
        merged_o = (old_word_i & ~merge_mask) | ((wdata_i << merge_shamt) & merge_mask);
        if (is_word(size_i)) begin
            merged_o = wdata_i;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word-addressed memory without byte enables.
// Define LSU_MISALIGN_EN to reject misaligned half/word accesses with rsp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_read_address_o,
    output logic [31:0]       mem_write_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    input  logic [DATA_W-1:0] mem_read_data_i
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        offset_q, offset_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged_word;
    logic [1:0]        req_offset;
    logic              req_misaligned;
    logic              unused_addr;

    assign unused_addr = ^req_addr_i[31:ADDR_W+2];

    // Misalignment check, and the offset actually latched for the access.
    always_comb begin
        req_misaligned = 1'b0;
        req_offset     = req_addr_i[1:0];
        if (is_word(req_size_i)) begin
            req_misaligned = (req_addr_i[1:0] != 2'b00);
            req_offset     = 2'b00;
        end else if (req_size_i == SZ_HALF) begin
            req_misaligned = req_addr_i[0];
            req_offset     = {req_addr_i[1], 1'b0};
        end
    end

    lsu_lane_align u_lane_align (
        .rd_word_i  (mem_read_data_i),
        .old_word_i (word_q),
        .wdata_i    (wdata_q),
        .offset_i   (offset_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .rdata_o    (load_data),
        .merged_o   (merged_word)
    );

`ifdef LSU_MISALIGN_EN
    logic rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        idx_d       = idx_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
`ifdef LSU_MISALIGN_EN
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d       = req_we_i;
                    size_d     = req_size_i;
                    unsigned_d = req_unsigned_i;
                    idx_d      = req_addr_i[ADDR_W+1:2];
                    offset_d   = req_offset;
                    wdata_d    = req_wdata_i;
                    if (req_we_i && is_word(req_size_i)) begin
                        word_d  = req_wdata_i;
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
`ifdef LSU_MISALIGN_EN
                    if (req_misaligned) begin
                        state_d = StErr;
                    end
`endif
                end
            end
            StRd: begin
                if (we_q) begin
                    word_d  = mem_read_data_i;
                    state_d = StMerge;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                    state_d     = StIdle;
                end
            end
            StMerge: begin
                word_d  = merged_word;
                state_d = StWr;
            end
            StWr: begin
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
`ifdef LSU_MISALIGN_EN
            StErr: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            idx_q       <= '0;
            offset_q    <= 2'b00;
            wdata_q     <= '0;
            word_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            idx_q       <= idx_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef LSU_MISALIGN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err_o = rsp_err_q;
`else
    logic unused_misaligned;
    assign unused_misaligned = req_misaligned;
    assign rsp_err_o = 1'b0;
`endif

    assign req_ready_o         = (state_q == StIdle);
    assign mem_read_o          = (state_q == StRd);
    assign mem_write_o         = (state_q == StWr);
    assign mem_read_address_o  = {{(32 - ADDR_W){1'b0}}, idx_q};
    assign mem_write_address_o = {{(32 - ADDR_W){1'b0}}, idx_q};
    assign mem_write_data_o    = mem_write_o ? word_q : '0;
    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_rdata_o         = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a negedge-capturing memory model and response scoreboard.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;

    logic [31:0] mem [32];
    rsp_t        exp_q [$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap_cnt = 0;
    logic [31:0] last_rd_idx = '0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_we_i            (req_we),
        .req_size_i          (req_size),
        .req_unsigned_i      (req_unsigned),
        .req_addr_i          (req_addr),
        .req_wdata_i         (req_wdata),
        .rsp_valid_o         (rsp_valid),
        .rsp_rdata_o         (rsp_rdata),
        .rsp_err_o           (rsp_err),
        .mem_read_o          (mem_read),
        .mem_write_o         (mem_write),
        .mem_read_address_o  (mem_read_address),
        .mem_write_address_o (mem_write_address),
        .mem_write_data_o    (mem_write_data),
        .mem_read_data_i     (mem_read_data)
    );

    // Word-addressed memory; resets to mem[i] = i and captures on negedge.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
            mem_read_data <= '0;
        end else begin
            if (mem_read) mem_read_data <= mem[mem_read_address[4:0]];
            if (mem_write) mem[mem_write_address[4:0]] <= mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        rsp_t e;
        @(negedge clk);
        if (mem_read && mem_write) overlap_cnt++;
        if (mem_read) begin
            rd_cnt++;
            last_rd_idx = mem_read_address;
        end
        if (mem_write) wr_cnt++;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, ".rdata"}, rsp_rdata, e.rdata);
                chk({e.tag, ".err"}, {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
    endtask

    task automatic send(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic want_rsp, input logic [31:0] exp_rdata, input logic exp_err);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (want_rsp) exp_q.push_back('{exp_rdata, exp_err, tag});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, ".rsp_err"}, {31'b0, rsp_err}, 32'd0);
        chk({tag, ".strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
        chk({tag, ".rd_addr"}, mem_read_address, 32'd0);
        chk({tag, ".wr_addr"}, mem_write_address, 32'd0);
        chk({tag, ".wr_data"}, mem_write_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // LW 0xC: one read cycle at index 3, response next cycle with ready high.
        rd_cnt = 0;
        send("lw_c", 1'b0, SZ_WORD, 1'b0, 32'h0000_000C, 32'h0, 1'b1, 32'h3, 1'b0);
        chk("lw_c.mem_read", {31'b0, mem_read}, 32'd1);
        chk("lw_c.rd_addr", mem_read_address, 32'd3);
        chk("lw_c.busy", {31'b0, req_ready}, 32'd0);
        tick();
        chk("lw_c.rsp_seen", 32'(exp_q.size()), 32'd0);
        chk("lw_c.ready_on_rsp", {31'b0, req_ready}, 32'd1);
        tick();
        chk("lw_c.rsp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("lw_c.rdata_drop", rsp_rdata, 32'd0);
        chk("lw_c.rd_cycles", 32'(rd_cnt), 32'd1);

        // SW then LW back-to-back.
        send("sw_10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
        chk("sw_10.mem_write", {31'b0, mem_write}, 32'd1);
        chk("sw_10.mem_read", {31'b0, mem_read}, 32'd0);
        chk("sw_10.wr_addr", mem_write_address, 32'd4);
        chk("sw_10.wr_data", mem_write_data, 32'hDEAD_BEEF);
        send("lw_10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        drain("s2");

        // Sub-word loads from 0xDEADBEEF.
        send("lb_13", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFF_FFDE, 1'b0);
        send("lbu_13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b1, 32'h0000_00DE, 1'b0);
        send("lh_12", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b1, 32'hFFFF_DEAD, 1'b0);
        send("lhu_10", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0);
        send("lb_11", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 1'b1, 32'hFFFF_FFBE, 1'b0);
        drain("s3");

        // Half store into upper lane of word 5 (holds 5).
        send("sh_16", 1'b1, SZ_HALF, 1'b0, 32'h16, 32'h1234_CAFE, 1'b1, 32'h0, 1'b0);
        send("lw_14", 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 1'b1, 32'hCAFE_0005, 1'b0);
        send("lb_17", 1'b0, SZ_BYTE, 1'b0, 32'h17, 32'h0, 1'b1, 32'hFFFF_FFCA, 1'b0);
        send("lhu_14", 1'b0, SZ_HALF, 1'b1, 32'h14, 32'h0, 1'b1, 32'h0000_0005, 1'b0);
        drain("sh");

        // SB 0x11 on 0x12345678: RD, MERGE, WR, then response.
        send("sw_1234", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1234_5678, 1'b1, 32'h0, 1'b0);
        drain("s4pre");
        rd_cnt = 0;
        wr_cnt = 0;
        send("sb_11", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_00AA, 1'b1, 32'h0, 1'b0);
        chk("sb_11.rd_state", {30'b0, mem_read, mem_write}, 32'd2);
        chk("sb_11.rd_addr", mem_read_address, 32'd4);
        chk("sb_11.busy1", {31'b0, req_ready}, 32'd0);
        tick();
        chk("sb_11.merge_state", {30'b0, mem_read, mem_write}, 32'd0);
        chk("sb_11.busy2", {31'b0, req_ready}, 32'd0);
        tick();
        chk("sb_11.wr_state", {30'b0, mem_read, mem_write}, 32'd1);
        chk("sb_11.wr_data", mem_write_data, 32'h1234_AA78);
        chk("sb_11.wr_addr", mem_write_address, 32'd4);
        chk("sb_11.busy3", {31'b0, req_ready}, 32'd0);
        tick();
        chk("sb_11.rsp_seen", 32'(exp_q.size()), 32'd0);
        chk("sb_11.ready_on_rsp", {31'b0, req_ready}, 32'd1);
        chk("sb_11.strobe_counts", {16'(rd_cnt), 16'(wr_cnt)}, {16'd1, 16'd1});
        send("lw_merged", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_AA78, 1'b0);
        drain("s4");

        // Reset during MERGE of a sub-word store: nothing written, outputs idle at once.
        wr_cnt = 0;
        send("sb_abort", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_0055, 1'b0, 32'h0, 1'b0);
        tick();
        chk("sb_abort.merge_state", {30'b0, mem_read, mem_write}, 32'd0);
        #1 rst = 1'b1;
        #1 chk_idle("rst_mid");
        tick();
        rst = 1'b0;
        chk("rst_mid.no_write", 32'(wr_cnt), 32'd0);
        send("lw_after_rst", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h4, 1'b0);
        drain("s5");

        // Misaligned accesses.
        rd_cnt = 0;
`ifdef LSU_MISALIGN_EN
        send("lw_e", 1'b0, SZ_WORD, 1'b0, 32'h0E, 32'h0, 1'b1, 32'h0, 1'b1);
        send("lh_11", 1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1);
        drain("s6");
        chk("misalign.no_read", 32'(rd_cnt), 32'd0);
`else
        send("lw_e", 1'b0, SZ_WORD, 1'b0, 32'h0E, 32'h0, 1'b1, 32'h3, 1'b0);
        drain("s6");
        chk("lw_e.rd_cycles", 32'(rd_cnt), 32'd1);
        chk("lw_e.rd_idx", last_rd_idx, 32'd3);
        send("lh_11", 1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 1'b1, 32'h4, 1'b0);
        drain("s6h");
`endif
        chk("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
